// File: rtl/fpu_result_buffer.sv
// Elastic FIFO stage after the FPU: buffers {result, status, tag} via valid/ready.
// Define FPU_RESULT_BUF_STICKY_FLAGS_EN to build the sticky fflags-style accumulator.
module fpu_result_buffer #(
    parameter int WIDTH     = 16,
    parameter int TAG_WIDTH = 1,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_result,
    input  logic [4:0]                   in_status,
    input  logic [TAG_WIDTH-1:0]         in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_result,
    output logic [4:0]                   out_status,
    output logic [TAG_WIDTH-1:0]         out_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [4:0]                   flags_o,
    input  logic                         flags_clr
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = WIDTH + 5 + TAG_WIDTH;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends only on registered occupancy: a full buffer refuses even during a pop.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only and deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_result, in_status, in_tag};
    end

    assign {out_result, out_status, out_tag} = mem[rd_ptr];

`ifdef FPU_RESULT_BUF_STICKY_FLAGS_EN
    logic [4:0] flags_q;

    // Clear takes priority over accumulation, so a simultaneous push seeds the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (flags_clr) begin
            flags_q <= push ? in_status : 5'b0;
        end else if (push) begin
            flags_q <= flags_q | in_status;
        end
    end

    assign flags_o = flags_q;
`else
    logic unused_flags_clr;

    assign unused_flags_clr = flags_clr;
    assign flags_o          = 5'b0;
`endif

endmodule

// File: doc/fpu_result_buffer.md
# fpu_result_buffer

Elastic output stage placed directly downstream of the FPU wrapper. Captures each completed result (result word, 5-bit IEEE status, tag) through a valid/ready handshake into a small FIFO, so the FPU never stalls while the consumer is momentarily busy. Optionally accumulates sticky exception flags across all accepted results, in the manner of an fflags CSR.

## Interface
- `WIDTH`, default 16: result word width; matches the FPU `Features.Width`.
- `TAG_WIDTH`, default 1: tag width.
- `DEPTH`, default 4: FIFO entries; legal range 2..16, any integer (need not be a power of two).
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  FPU result valid; connected to `out_valid_o`.
- `in_ready`  out  1  buffer can accept; connected to FPU `out_ready_i`.
- `in_result`  in  WIDTH  FPU `result_o`.
- `in_status`  in  5  FPU `status_o` as {NV,DZ,OF,UF,NX}.
- `in_tag`  in  TAG_WIDTH  FPU `tag_o`.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head.
- `out_result`  out  WIDTH  head result.
- `out_status`  out  5  head status.
- `out_tag`  out  TAG_WIDTH  head tag.
- `count`  out  $clog2(DEPTH+1)  number of occupied entries.
- `flags_o`  out  5  sticky accumulated status.
- `flags_clr`  in  1  synchronous clear of `flags_o`.

## Operation
- Storage: DEPTH-entry circular buffer; write pointer, read pointer, occupancy counter.
- Push = `in_valid && in_ready`. Writes {result,status,tag} at write pointer; write pointer advances.
- Pop = `out_valid && out_ready`. Read pointer advances.
- Pointers wrap from DEPTH-1 to 0 explicitly. DEPTH is not required to be a power of two.
- `count` updates as follows: +1 on push only, -1 on pop only, unchanged on push and pop together.
- `in_ready` = (`count` != DEPTH). It depends on registered state only; there is no combinational path from `out_ready`. When the buffer is full, a push is refused even if a pop occurs in the same cycle.
- `out_valid` = (`count` != 0).
- `out_result`, `out_status`, `out_tag` show the head entry. They are don't-care while `out_valid`=0, and the bench must not check them then.
- Holding rule: while `out_valid`=1 and `out_ready`=0, the head fields stay stable.
- Push and pop in the same cycle at `count`=1: the old head leaves, the new entry becomes the head next cycle, and `count` stays at 1.
- Data order: strictly FIFO. Tags are passed through unmodified and are not interpreted.

## Timing
- Reset values (asynchronous, applied immediately on `rst`=1): pointers=0, `count`=0, `in_ready`=1, `out_valid`=0, `flags_o`=0. Storage contents are not reset.
- Reset asserted mid-operation discards all buffered entries. Entries offered or popped in the reset cycle are lost or ignored.
- Latency: an entry pushed at edge N is visible with `out_valid`=1 after edge N. It can be popped at edge N+1 at the earliest.
- There is no fall-through bypass. An empty buffer adds exactly 1 cycle.
- Throughput: 1 entry/cycle sustained whenever 0 < `count` < DEPTH.
- `flags_o` updates on the same edge as the push.

## Configuration
- Macro `FPU_RESULT_BUF_STICKY_FLAGS_EN`.
- Defined:
  - On each push, `flags_o <= flags_o | in_status`.
  - `flags_clr`=1 clears `flags_o` to 0.
  - If `flags_clr` and a push occur together, the clear applies first: `flags_o <= in_status`.
  - Pops never affect `flags_o`.
- Undefined:
  - No flag register is built.
  - `flags_o` is constant 0 and `flags_clr` is ignored.
  - All FIFO behaviour is identical.

## Test plan
- Reset then idle: `out_valid`=0, `in_ready`=1, `count`=0, `flags_o`=0.
- Push 3 entries (results 0x3C00, 0x4000, 0x4200; tags 0, 1, 0) with `out_ready`=0, then hold `out_ready`=1. Required: `count` goes 1, 2, 3; the entries come out in the same order with matching tags on 3 consecutive cycles; `count` returns to 0.
- Fill to DEPTH=4 with `out_ready`=0:
  - `in_ready` drops to 0 after the 4th push.
  - A 5th `in_valid` entry offered in the same cycle as a pop is not accepted.
  - The next cycle `in_ready`=1 and `count`=3.
- Continuous `in_valid` with `out_ready` toggling every cycle for 20 entries, spanning several wrap-arounds. Required: the output sequence equals the input sequence with no loss or duplication.
- With the macro defined:
  - Push statuses 0b00001 then 0b10000; `flags_o`=0b10001.
  - Assert `flags_clr` together with a push of status 0b00100; `flags_o`=0b00100.
  - Without the macro, `flags_o` stays 0 throughout.
- Assert `rst` asynchronously while `count`=2. Required: `out_valid`=0 and `count`=0 immediately (before the next edge); the first post-reset push is the head.
